// File: rtl/board_uart_tx.sv
// board_uart_tx: snapshots the 256-bit board and 14-bit move word on request
// and sends them as one 36-byte 8N1 UART packet.
// Packet order: header 0xA5, 32 board bytes, two move bytes, XOR checksum.
module board_uart_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         send,
    input  logic [255:0] board,
    input  logic [13:0]  moveData,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
    localparam logic [5:0]  LAST_BYTE = 6'd35;
    localparam logic [7:0]  HEADER    = 8'hA5;

    state_t         state, state_n;
    logic [15:0]    bit_cnt, bit_cnt_n;
    logic [2:0]     bit_idx, bit_idx_n;
    logic [5:0]     byte_idx, byte_idx_n;
    logic [7:0]     shift_byte, shift_byte_n;
    logic [7:0]     csum, csum_n;
    logic [255:0]   snap_board, snap_board_n;
    logic [13:0]    snap_move, snap_move_n;
    logic           tx_q, tx_n;
    logic           busy_q, busy_n;
    logic           done_q, done_n;

    logic [5:0]     next_idx;
    logic [7:0]     next_byte;

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

    // Select the byte that follows the current one; board byte k-1 sits at index k,
    // so the board slice for the next byte is addressed by the current index.
    always_comb begin
        next_idx  = byte_idx + 6'd1;
        next_byte = csum;
        if (next_idx <= 6'd32) begin
            next_byte = snap_board[{byte_idx[4:0], 3'b000} +: 8];
        end else if (next_idx == 6'd33) begin
            next_byte = {2'b00, snap_move[13:8]};
        end else if (next_idx == 6'd34) begin
            next_byte = snap_move[7:0];
        end
    end

    // Next-state and next-output logic for the framing FSM.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        bit_idx_n    = bit_idx;
        byte_idx_n   = byte_idx;
        shift_byte_n = shift_byte;
        csum_n       = csum;
        snap_board_n = snap_board;
        snap_move_n  = snap_move;
        tx_n         = tx_q;
        busy_n       = busy_q;
        done_n       = 1'b0;

        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (send) begin
                    snap_board_n = board;
                    snap_move_n  = moveData;
                    byte_idx_n   = 6'd0;
                    csum_n       = 8'd0;
                    shift_byte_n = HEADER;
                    bit_cnt_n    = 16'd0;
                    bit_idx_n    = 3'd0;
                    busy_n       = 1'b1;
                    tx_n         = 1'b0;
                    state_n      = START_BIT;
                end
            end
            START_BIT: begin
                if (bit_cnt == LAST_CNT) begin
                    bit_cnt_n = 16'd0;
                    bit_idx_n = 3'd0;
                    tx_n      = shift_byte[0];
                    state_n   = DATA_BITS;
                end else begin
                    bit_cnt_n = bit_cnt + 16'd1;
                end
            end
            DATA_BITS: begin
                if (bit_cnt == LAST_CNT) begin
                    bit_cnt_n = 16'd0;
                    if (bit_idx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP_BIT;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = shift_byte[bit_idx + 3'd1];
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 16'd1;
                end
            end
            STOP_BIT: begin
                if (bit_cnt == LAST_CNT) begin
                    bit_cnt_n = 16'd0;
                    if (byte_idx == LAST_BYTE) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        tx_n    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        byte_idx_n   = next_idx;
                        shift_byte_n = next_byte;
                        if (next_idx != LAST_BYTE) begin
                            csum_n = csum ^ next_byte;
                        end
                        tx_n    = 1'b0;
                        state_n = START_BIT;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 16'd0;
            bit_idx    <= 3'd0;
            byte_idx   <= 6'd0;
            shift_byte <= 8'd0;
            csum       <= 8'd0;
            snap_board <= 256'd0;
            snap_move  <= 14'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            bit_idx    <= bit_idx_n;
            byte_idx   <= byte_idx_n;
            shift_byte <= shift_byte_n;
            csum       <= csum_n;
            snap_board <= snap_board_n;
            snap_move  <= snap_move_n;
            tx_q       <= tx_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
        end
    end

endmodule

// File: tb/tb_board_uart_tx.sv
// Testbench for board_uart_tx: decodes the serial line by cycle position
// and compares each packet byte and the busy/done timing against expectations.
module tb_board_uart_tx;

    localparam int CPB          = 4;
    localparam int FRAME_CYCLES = 36 * 10 * CPB;

    logic         clk = 1'b0;
    logic         reset;
    logic         send;
    logic [255:0] board;
    logic [13:0]  moveData;
    logic         tx;
    logic         busy;
    logic         done;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] rx_bytes  [36];
    logic [7:0] exp_bytes [36];
    int         rx_busy_cycles;
    int         rx_wait;
    int         rx_frame_err;
    logic       rx_done_now;
    logic       rx_timeout;

    board_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .reset    (reset),
        .send     (send),
        .board    (board),
        .moveData (moveData),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case something stalls far beyond the expected run length.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference packet built straight from the packet layout.
    task automatic build_expected(input logic [255:0] b, input logic [13:0] m);
        logic [7:0] cs;
        cs = 8'd0;
        exp_bytes[0] = 8'hA5;
        for (int k = 1; k <= 32; k++) exp_bytes[k] = b[8*(k-1) +: 8];
        exp_bytes[33] = {2'b00, m[13:8]};
        exp_bytes[34] = m[7:0];
        for (int k = 1; k <= 34; k++) cs = cs ^ exp_bytes[k];
        exp_bytes[35] = cs;
    endtask

    task automatic pulse_send;
        @(posedge clk); #1 send = 1'b1;
        @(posedge clk); #1 send = 1'b0;
    endtask

    // Waits for busy, then samples tx once per bit slot at negedges; returns at the
    // first negedge with busy low, which should be the done cycle.
    task automatic capture_frame;
        int k;
        int slot;
        int pos;
        int b;
        rx_timeout     = 1'b0;
        rx_frame_err   = 0;
        rx_busy_cycles = 0;
        rx_wait        = 0;
        rx_done_now    = 1'b0;
        for (int i = 0; i < 36; i++) rx_bytes[i] = 8'h00;
        do begin
            @(negedge clk);
            rx_wait++;
        end while (busy !== 1'b1 && rx_wait < 50);
        if (busy !== 1'b1) begin
            rx_timeout = 1'b1;
            return;
        end
        k = 0;
        while (busy === 1'b1 && k < FRAME_CYCLES + 100) begin
            if (k % CPB == 1) begin
                slot = k / CPB;
                b    = slot / 10;
                pos  = slot % 10;
                if (b < 36) begin
                    if (pos == 0) begin
                        if (tx !== 1'b0) rx_frame_err++;
                    end else if (pos == 9) begin
                        if (tx !== 1'b1) rx_frame_err++;
                    end else begin
                        rx_bytes[b][pos-1] = tx;
                    end
                end
            end
            if (done !== 1'b0) rx_frame_err++;
            k++;
            @(negedge clk);
        end
        rx_busy_cycles = k;
        if (busy === 1'b1) rx_timeout = 1'b1;
        rx_done_now = done;
    endtask

    task automatic test_reset;
        int bad;
        reset = 1'b1; send = 1'b0; board = '0; moveData = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tx got %b want 1", tx); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done); end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("[TB] FAIL idle_100 bad cycles got %0d want 0", bad); end
    endtask

    task automatic test_basic;
        board = '0; moveData = 14'h2000;
        build_expected(board, moveData);
        pulse_send();
        capture_frame();
        vectors++; if (rx_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_timeout got %b want 0", rx_timeout); end
        vectors++; if (rx_bytes[0] !== 8'hA5) begin miscompares++; $display("[TB] FAIL basic_header got %h want a5", rx_bytes[0]); end
        vectors++; if (rx_bytes[33] !== 8'h20) begin miscompares++; $display("[TB] FAIL basic_move_hi got %h want 20", rx_bytes[33]); end
        vectors++; if (rx_bytes[35] !== 8'h20) begin miscompares++; $display("[TB] FAIL basic_checksum got %h want 20", rx_bytes[35]); end
        for (int i = 0; i < 36; i++) begin
            vectors++;
            if (rx_bytes[i] !== exp_bytes[i]) begin
                miscompares++; $display("[TB] FAIL basic_byte%0d got %h want %h", i, rx_bytes[i], exp_bytes[i]);
            end
        end
        vectors++; if (rx_busy_cycles !== FRAME_CYCLES) begin miscompares++; $display("[TB] FAIL basic_busy_len got %0d want %0d", rx_busy_cycles, FRAME_CYCLES); end
        vectors++; if (rx_frame_err !== 0) begin miscompares++; $display("[TB] FAIL basic_framing errors got %0d want 0", rx_frame_err); end
        vectors++; if (rx_done_now !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_done got %b want 1", rx_done_now); end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_done_width got %b want 0", done); end
    endtask

    task automatic test_pattern;
        board = '0; board[7:0] = 8'h61; board[255:248] = 8'h9C; moveData = 14'h0ABC;
        build_expected(board, moveData);
        pulse_send();
        capture_frame();
        vectors++; if (rx_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL pat_timeout got %b want 0", rx_timeout); end
        vectors++; if (rx_bytes[1] !== 8'h61) begin miscompares++; $display("[TB] FAIL pat_byte1 got %h want 61", rx_bytes[1]); end
        vectors++; if (rx_bytes[32] !== 8'h9C) begin miscompares++; $display("[TB] FAIL pat_byte32 got %h want 9c", rx_bytes[32]); end
        vectors++; if (rx_bytes[33] !== 8'h0A) begin miscompares++; $display("[TB] FAIL pat_byte33 got %h want 0a", rx_bytes[33]); end
        vectors++; if (rx_bytes[34] !== 8'hBC) begin miscompares++; $display("[TB] FAIL pat_byte34 got %h want bc", rx_bytes[34]); end
        // 61 ^ 9C ^ 0A ^ BC = 4B
        vectors++; if (rx_bytes[35] !== 8'h4B) begin miscompares++; $display("[TB] FAIL pat_checksum got %h want 4b", rx_bytes[35]); end
        for (int i = 0; i < 36; i++) begin
            vectors++;
            if (rx_bytes[i] !== exp_bytes[i]) begin
                miscompares++; $display("[TB] FAIL pat_byte%0d got %h want %h", i, rx_bytes[i], exp_bytes[i]);
            end
        end
        vectors++; if (rx_done_now !== 1'b1) begin miscompares++; $display("[TB] FAIL pat_done got %b want 1", rx_done_now); end
    endtask

    task automatic test_snapshot;
        int extra;
        board = {8{32'hDEAD_5A3C}}; moveData = 14'h1357;
        build_expected(board, moveData);
        pulse_send();
        fork
            capture_frame();
            begin
                repeat (10) @(posedge clk);
                for (int i = 0; i < 300; i++) begin
                    @(posedge clk);
                    #1 board = {8{$urandom()}};
                    moveData = 14'($urandom());
                    send = (i % 3 == 0);
                end
                send = 1'b0;
            end
        join
        vectors++; if (rx_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL snap_timeout got %b want 0", rx_timeout); end
        for (int i = 0; i < 36; i++) begin
            vectors++;
            if (rx_bytes[i] !== exp_bytes[i]) begin
                miscompares++; $display("[TB] FAIL snap_byte%0d got %h want %h", i, rx_bytes[i], exp_bytes[i]);
            end
        end
        vectors++; if (rx_busy_cycles !== FRAME_CYCLES) begin miscompares++; $display("[TB] FAIL snap_busy_len got %0d want %0d", rx_busy_cycles, FRAME_CYCLES); end
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) extra++;
        end
        vectors++; if (extra !== 0) begin miscompares++; $display("[TB] FAIL snap_no_queue busy cycles got %0d want 0", extra); end
    endtask

    task automatic test_reset_midframe;
        int bad;
        board = {32{8'h3C}}; moveData = 14'h3FFF;
        pulse_send();
        // byte 10 occupies cycles 400..439 after acceptance
        repeat (405) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_mid_busy_before got %b want 1", busy); end
        @(posedge clk);
        @(negedge clk);
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_mid_tx got %b want 1", tx); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_busy got %b want 0", busy); end
        @(posedge clk);
        #1 reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("[TB] FAIL rst_mid_no_done bad cycles got %0d want 0", bad); end
        board = '0; board[127:120] = 8'hC3; board[15:8] = 8'h11; moveData = 14'h2A55;
        build_expected(board, moveData);
        pulse_send();
        capture_frame();
        vectors++; if (rx_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_after_timeout got %b want 0", rx_timeout); end
        for (int i = 0; i < 36; i++) begin
            vectors++;
            if (rx_bytes[i] !== exp_bytes[i]) begin
                miscompares++; $display("[TB] FAIL rst_after_byte%0d got %h want %h", i, rx_bytes[i], exp_bytes[i]);
            end
        end
        vectors++; if (rx_done_now !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_after_done got %b want 1", rx_done_now); end
    endtask

    task automatic test_back_to_back;
        board = {16{16'hF00D}}; moveData = 14'h0123;
        build_expected(board, moveData);
        @(posedge clk); #1 send = 1'b1;
        capture_frame();
        vectors++; if (rx_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b1_timeout got %b want 0", rx_timeout); end
        vectors++; if (rx_done_now !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b1_done got %b want 1", rx_done_now); end
        vectors++; if (rx_bytes[35] !== exp_bytes[35]) begin miscompares++; $display("[TB] FAIL b2b1_checksum got %h want %h", rx_bytes[35], exp_bytes[35]); end
        fork
            capture_frame();
            begin
                repeat (100) @(posedge clk);
                #1 send = 1'b0;
            end
        join
        vectors++; if (rx_wait !== 1) begin miscompares++; $display("[TB] FAIL b2b_gap cycles got %0d want 1", rx_wait); end
        vectors++; if (rx_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b2_timeout got %b want 0", rx_timeout); end
        for (int i = 0; i < 36; i++) begin
            vectors++;
            if (rx_bytes[i] !== exp_bytes[i]) begin
                miscompares++; $display("[TB] FAIL b2b2_byte%0d got %h want %h", i, rx_bytes[i], exp_bytes[i]);
            end
        end
        vectors++; if (rx_busy_cycles !== FRAME_CYCLES) begin miscompares++; $display("[TB] FAIL b2b2_busy_len got %0d want %0d", rx_busy_cycles, FRAME_CYCLES); end
        vectors++; if (rx_done_now !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b2_done got %b want 1", rx_done_now); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_end_busy got %b want 0", busy); end
    endtask

    // Scenario sequence and summary.
    initial begin
        reset = 1'b1; send = 1'b0; board = '0; moveData = '0;
        test_reset();
        test_basic();
        test_pattern();
        test_snapshot();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
